div: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 24 ++
 rtl/div.sv | 143 ++++++++++++++
 tb/tb_div.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  localparam int unsigned DIV_XLEN = 32;

  // Divider control FSM encoding
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Per-operation control captured when the operation starts
  typedef struct packed {
    logic rem_sel;   // return remainder instead of quotient
    logic sign_q;    // quotient must be negated
    logic sign_r;    // remainder must be negated
    logic special;   // divide-by-zero or signed overflow, result preloaded
  } div_ctl_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in one dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            din,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next_c,
  output logic            q_bit_c
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The partial remainder is always below the divisor, so the XLEN+1 bit
  // shifted value and its trial difference never overflow; trial's MSB is the borrow.
  always_comb begin
    shifted    = {rem, din};
    trial      = shifted - {1'b0, divisor};
    q_bit_c    = ~trial[XLEN];
    rem_next_c = q_bit_c ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, stalling EX until div_done.
module div
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_is_div_inst,
  input  logic            ex_rem_sel,
  input  logic            ex_div_signed,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  output logic            div_done,
  output logic [XLEN-1:0] div_res
);

  localparam int unsigned     CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  div_ctl_t         ctl_q, ctl_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             done_q, done_d;

  logic [XLEN-1:0]  step_rem_c;
  logic             step_q_c;
  logic [XLEN-1:0]  quo_shift;
  logic [XLEN-1:0]  d1_abs;
  logic [XLEN-1:0]  d2_abs;
  logic             div_zero;
  logic             div_ovf;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  // Single restoring step on the current partial remainder and next dividend bit
  div_step #(.XLEN(XLEN)) u_step (
    .rem        (rem_q),
    .din        (quo_q[XLEN-1]),
    .divisor    (dvs_q),
    .rem_next_c (step_rem_c),
    .q_bit_c    (step_q_c)
  );

  // Next-state, datapath and result selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    ctl_d     = ctl_q;
    res_d     = res_q;
    done_d    = 1'b0;
    quo_shift = {quo_q[XLEN-2:0], step_q_c};
    d1_abs    = neg_if(d1, ex_div_signed & d1[XLEN-1]);
    d2_abs    = neg_if(d2, ex_div_signed & d2[XLEN-1]);
    div_zero  = (d2 == '0);
    div_ovf   = ex_div_signed & (d1 == XMIN) & (d2 == '1);

    unique case (state_q)
      DIV_IDLE: begin
        if (ex_is_div_inst) begin
          ctl_d.rem_sel = ex_rem_sel;
          ctl_d.sign_q  = ex_div_signed & (d1[XLEN-1] ^ d2[XLEN-1]);
          ctl_d.sign_r  = ex_div_signed & d1[XLEN-1];
          ctl_d.special = div_zero | div_ovf;
          quo_d         = d1_abs;
          dvs_d         = d2_abs;
          cnt_d         = '0;
          rem_d         = '0;
          if (div_zero) begin
            res_d   = ex_rem_sel ? d1 : '1;
            state_d = DIV_DONE;
            done_d  = 1'b1;
          end else if (div_ovf) begin
            res_d   = ex_rem_sel ? '0 : XMIN;
            state_d = DIV_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        if (!ex_is_div_inst) begin
          // Squashed by flush: drop the operation, keep the previous result
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem_c;
          quo_d = quo_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_d   = ctl_q.rem_sel ? neg_if(step_rem_c, ctl_q.sign_r)
                                    : neg_if(quo_shift, ctl_q.sign_q);
            state_d = DIV_DONE;
            done_d  = 1'b1;
          end
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign div_done = done_q;
  assign div_res  = res_q;

endmodule

// File: tb/tb_div.sv
// Randomized scoreboard bench for the iterative divider.
module tb_div;

  logic        clk;
  logic        rst_n;
  logic        ex_is_div_inst;
  logic        ex_rem_sel;
  logic        ex_div_signed;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        div_done;
  logic [31:0] div_res;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  div #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_is_div_inst (ex_is_div_inst),
    .ex_rem_sel     (ex_rem_sel),
    .ex_div_signed  (ex_div_signed),
    .d1             (d1),
    .d2             (d2),
    .div_done       (div_done),
    .div_res        (div_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RISC-V division semantics via wide integer arithmetic
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic rs, input logic sg);
    longint      sa;
    longint      sbv;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = 32'(sa / sbv);
      r   = 32'(sa % sbv);
    end else begin
      q = a / b;
      r = a % b;
    end
    return rs ? r : q;
  endfunction

  function automatic int unsigned latency(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg);
    if (b == 32'h0) return 1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every div_done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && div_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: div_done=1 res=%h in cycle %0d, none expected",
                   div_res, cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (div_res !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", e.name, div_res, e.res);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s latency: done in cycle %0d expected %0d", e.name, cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rs,
                        input logic sg, input bit toggle, input string nm);
    int unsigned start;
    bit          seen;
    exp_t        e;
    @(posedge clk);
    #1;
    d1             = a;
    d2             = b;
    ex_rem_sel     = rs;
    ex_div_signed  = sg;
    ex_is_div_inst = 1'b1;
    start          = cyc;
    e.res  = model(a, b, rs, sg);
    e.cyc  = start + latency(a, b, sg);
    e.name = nm;
    sb.push_back(e);
    last_exp = e.res;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (div_done) seen = 1'b1;
      else if (toggle && cyc != start) begin
        d1            = $urandom;
        d2            = $urandom;
        ex_rem_sel    = ~ex_rem_sel;
        ex_div_signed = ~ex_div_signed;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: div_done=0 after 60 cycles, required 1", nm);
      sb.delete(sb.size() - 1);
    end
    @(posedge clk);
    #1;
    ex_is_div_inst = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int unsigned sel;

    rst_n          = 1'b0;
    ex_is_div_inst = 1'b0;
    ex_rem_sel     = 1'b0;
    ex_div_signed  = 1'b0;
    d1             = 32'h0;
    d2             = 32'h0;
    #2;
    checks++;
    if (div_done !== 1'b0 || div_res !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: done=%b res=%h required 0/00000000", div_done, div_res);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, "divu_100_7");
    run_op(32'd100, 32'd7, 1'b1, 1'b0, 1'b0, "remu_100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0, "div_m7_2");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0, "rem_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, "rem_7_m2");
    run_op(32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0, "div_by_zero");
    run_op(32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b0, "remu_by_zero");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, "div_ovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "rem_ovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "divu_big");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "remu_big");

    // Abort in CALC: no done pulse, previous result held
    @(posedge clk);
    #1;
    d1 = 32'd55; d2 = 32'd3; ex_rem_sel = 1'b0; ex_div_signed = 1'b0;
    ex_is_div_inst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ex_is_div_inst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (div_res !== last_exp) begin
      errors++;
      $display("FAIL abort_hold: res=%h required %h", div_res, last_exp);
    end
    run_op(32'd1000, 32'd10, 1'b0, 1'b0, 1'b0, "after_abort");

    // Asynchronous reset in the middle of an operation
    @(posedge clk);
    #1;
    d1 = 32'd999; d2 = 32'd4; ex_rem_sel = 1'b0; ex_div_signed = 1'b0;
    ex_is_div_inst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (div_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_done: done=%b required 0", div_done);
    end
    checks++;
    if (div_res !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_res: res=%h required 00000000", div_res);
    end
    ex_is_div_inst = 1'b0;
    last_exp = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back with operands disturbed during CALC
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 1'b1, "b2b_divu");
    run_op(32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0, 1'b1, "b2b_remu");

    // Randomized operations with extra weight on edge operands
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      case (sel)
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    repeat (5) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
